led_run_multi_module: RTL and testbench



---
 rtl/led_run_multi_module.sv | 129 ++++++++++++
 tb/tb_led_run_multi_module.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_run_multi_module.sv
// Running-LED driver: LED_W-wide bank stepped by a speed-selectable tick divider,
// with rotate-right, rotate-left, bounce and fill-bar animations.
module led_run_multi_module #(
  parameter int               LED_W    = 8,
  parameter int               CNT_W    = 26,
  parameter logic [CNT_W-1:0] TICK_DIV = 26'd50000000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             En,
  input  logic [1:0]       Mode,
  input  logic [1:0]       Speed,
  output logic [LED_W-1:0] LED_Out,
  output logic             Step_Pulse
);

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  localparam logic [LED_W-1:0] LED_ZERO = {LED_W{1'b0}};
  localparam logic [LED_W-1:0] LED_ONE  = {{(LED_W-1){1'b0}}, 1'b1};
  localparam logic [LED_W-1:0] LED_ALL  = {LED_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic is_onehot(input logic [LED_W-1:0] v);
    return (v != LED_ZERO) && ((v & (v - LED_ONE)) == LED_ZERO);
  endfunction

  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [LED_W-1:0] led_r, led_nxt_s;
  logic             step_r, step_nxt_s;
  dir_e             dir_r, dir_nxt_s;
  logic [1:0]       mode_r;

  logic [CNT_W-1:0] period_s;
  logic             tick_s;
  logic             reload_s;
  logic [LED_W-1:0] shl_s;
  logic [LED_W-1:0] shr_s;

  assign period_s = TICK_DIV >> Speed;
  assign tick_s   = En && (cnt_r >= (period_s - CNT_ONE));
  assign reload_s = (Mode != mode_r);
  assign shl_s    = {led_r[LED_W-2:0], 1'b0};
  assign shr_s    = {1'b0, led_r[LED_W-1:1]};

  // Next-state: reload beats tick beats count/hold; only a tick strobes Step_Pulse
  always_comb begin
    cnt_nxt_s  = cnt_r;
    led_nxt_s  = led_r;
    dir_nxt_s  = dir_r;
    step_nxt_s = 1'b0;
    if (reload_s) begin
      cnt_nxt_s = CNT_ZERO;
      dir_nxt_s = DIR_LEFT;
      led_nxt_s = (Mode == 2'b11) ? LED_ZERO : LED_ONE;
    end else if (tick_s) begin
      cnt_nxt_s  = CNT_ZERO;
      step_nxt_s = 1'b1;
      case (mode_r)
        2'b00: begin
          if (!is_onehot(led_r)) begin
            led_nxt_s = LED_ONE;
          end else begin
            led_nxt_s = {led_r[0], led_r[LED_W-1:1]};
          end
        end
        2'b01: begin
          if (!is_onehot(led_r)) begin
            led_nxt_s = LED_ONE;
          end else begin
            led_nxt_s = {led_r[LED_W-2:0], led_r[LED_W-1]};
          end
        end
        2'b10: begin
          // Direction flips as an endpoint is reached, so each end shows for one step
          if (!is_onehot(led_r)) begin
            led_nxt_s = LED_ONE;
            dir_nxt_s = DIR_LEFT;
          end else if (dir_r == DIR_LEFT) begin
            led_nxt_s = shl_s;
            dir_nxt_s = shl_s[LED_W-1] ? DIR_RIGHT : DIR_LEFT;
          end else begin
            led_nxt_s = shr_s;
            dir_nxt_s = shr_s[0] ? DIR_LEFT : DIR_RIGHT;
          end
        end
        2'b11: begin
          if (led_r == LED_ALL) begin
            led_nxt_s = LED_ZERO;
          end else begin
            led_nxt_s = {led_r[LED_W-2:0], 1'b1};
          end
        end
        default: begin
          led_nxt_s = led_r;
        end
      endcase
    end else if (En) begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // State register with synchronous reset taking priority over all inputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_r  <= CNT_ZERO;
      led_r  <= LED_ONE;
      step_r <= 1'b0;
      dir_r  <= DIR_LEFT;
      mode_r <= 2'b00;
    end else begin
      cnt_r  <= cnt_nxt_s;
      led_r  <= led_nxt_s;
      step_r <= step_nxt_s;
      dir_r  <= dir_nxt_s;
      mode_r <= Mode;
    end
  end

  assign LED_Out    = led_r;
  assign Step_Pulse = step_r;

endmodule

// File: tb/tb_led_run_multi_module.sv
// Scoreboard bench for led_run_multi_module with TICK_DIV=8, LED_W=8: expected
// steps (pattern and cycle) are queued at stimulus time and checked on Step_Pulse.
module tb_led_run_multi_module;

  logic       CLK   = 1'b0;
  logic       RST   = 1'b1;
  logic       En    = 1'b0;
  logic [1:0] Mode  = 2'b00;
  logic [1:0] Speed = 2'b00;
  logic [7:0] LED_Out;
  logic       Step_Pulse;

  int cyc   = 0;
  int n_chk = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0] led;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t got_e;

  logic [7:0] bnc_seq [16] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                               8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};
  logic [7:0] fill_seq [9] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h00};

  led_run_multi_module #(
    .LED_W   (8),
    .CNT_W   (26),
    .TICK_DIV(26'd8)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .En        (En),
    .Mode      (Mode),
    .Speed     (Speed),
    .LED_Out   (LED_Out),
    .Step_Pulse(Step_Pulse)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h (cyc %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic expect_step(input logic [7:0] led, input int at);
    exp_t e;
    e.led = led;
    e.cyc = at;
    exp_q.push_back(e);
  endtask

  // Every strobe must match the head of the scoreboard in pattern and cycle
  always @(negedge CLK) begin
    if (Step_Pulse) begin
      if (exp_q.size() == 0) begin
        chk("spurious_step", 32'(Step_Pulse), 32'd0);
      end else begin
        got_e = exp_q.pop_front();
        chk("step_led", 32'(LED_Out), 32'(got_e.led));
        chk("step_cyc", 32'(cyc), 32'(got_e.cyc));
      end
    end
  end

  task automatic start(input logic [1:0] m, input logic [1:0] s, output int c);
    @(negedge CLK);
    RST   = 1'b1;
    En    = 1'b1;
    Mode  = m;
    Speed = s;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    c   = cyc;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge CLK);
  endtask

  task automatic stop_at(input int t);
    wait_cyc(t);
    En = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge CLK);
    chk(tag, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int c;
    int t;

    // Reset state and first steps in rotate-right at P=8
    @(negedge CLK);
    RST = 1'b1; Mode = 2'b00; Speed = 2'b00; En = 1'b1;
    repeat (2) @(negedge CLK);
    chk("rst_led",   32'(LED_Out), 32'h01);
    chk("rst_pulse", 32'(Step_Pulse), 32'd0);
    chk("rst_cnt",   32'(dut.cnt_r), 32'd0);
    chk("rst_dir",   32'(dut.dir_r), 32'd0);
    chk("rst_mode",  32'(dut.mode_r), 32'd0);
    RST = 1'b0;
    c   = cyc;
    expect_step(8'h80, c + 8);
    expect_step(8'h40, c + 16);
    stop_at(c + 16);
    drain("rst_seq");

    // Bounce at P=1
    start(2'b10, 2'b11, c);
    for (int k = 0; k < 16; k++) expect_step(bnc_seq[k], c + 2 + k);
    stop_at(c + 17);
    drain("bnc_seq");
    chk("bnc_dir", 32'(dut.dir_r), 32'd0);

    // Fill-bar at P=2
    start(2'b11, 2'b10, c);
    for (int k = 0; k < 9; k++) expect_step(fill_seq[k], c + 3 + 2 * k);
    wait_cyc(c + 1);
    chk("fill_reload", 32'(LED_Out), 32'h00);
    stop_at(c + 19);
    drain("fill_seq");

    // Pause mid-count, then speed-up while Count=5
    start(2'b00, 2'b00, c);
    wait_cyc(c + 3);
    En = 1'b0;
    repeat (20) @(negedge CLK);
    chk("pause_led",   32'(LED_Out), 32'h01);
    chk("pause_cnt",   32'(dut.cnt_r), 32'd3);
    chk("pause_dir",   32'(dut.dir_r), 32'd0);
    chk("pause_pulse", 32'(Step_Pulse), 32'd0);
    expect_step(8'h80, c + 26);
    expect_step(8'h40, c + 27);
    expect_step(8'h20, c + 28);
    En = 1'b1;
    wait_cyc(c + 25);
    chk("spd_cnt5", 32'(dut.cnt_r), 32'd5);
    Speed = 2'b11;
    stop_at(c + 28);
    drain("spd_seq");
    chk("spd_cnt_end", 32'(dut.cnt_r), 32'd0);

    // Mode change in the same cycle as a tick
    start(2'b10, 2'b00, c);
    expect_step(8'h02, c + 9);
    wait_cyc(c + 16);
    Mode = 2'b01;
    wait_cyc(c + 17);
    chk("race_led",   32'(LED_Out), 32'h01);
    chk("race_pulse", 32'(Step_Pulse), 32'd0);
    expect_step(8'h02, c + 25);
    stop_at(c + 25);
    drain("race_seq");

    // Reset together with a tick
    start(2'b00, 2'b00, c);
    expect_step(8'h80, c + 8);
    wait_cyc(c + 15);
    RST = 1'b1;
    wait_cyc(c + 16);
    chk("rrace_led",   32'(LED_Out), 32'h01);
    chk("rrace_cnt",   32'(dut.cnt_r), 32'd0);
    chk("rrace_pulse", 32'(Step_Pulse), 32'd0);
    RST = 1'b0;
    c   = cyc;
    expect_step(8'h80, c + 8);
    stop_at(c + 8);
    drain("rrace_seq");

    // Recovery from all-zero in rotate-right
    start(2'b00, 2'b00, c);
    wait_cyc(c + 2);
    force dut.led_r = 8'h00;
    wait_cyc(c + 3);
    release dut.led_r;
    chk("frc0", 32'(LED_Out), 32'h00);
    expect_step(8'h01, c + 8);
    expect_step(8'h80, c + 16);
    stop_at(c + 16);
    drain("rcv0_seq");

    // Recovery from multi-bit in bounce while travelling right
    start(2'b10, 2'b11, c);
    for (int k = 0; k < 8; k++) expect_step(bnc_seq[k], c + 2 + k);
    stop_at(c + 9);
    drain("rcv_pre");
    chk("rcv_dir_right", 32'(dut.dir_r), 32'd1);
    @(negedge CLK);
    force dut.led_r = 8'h05;
    @(negedge CLK);
    release dut.led_r;
    chk("frc5", 32'(LED_Out), 32'h05);
    t = cyc;
    expect_step(8'h01, t + 1);
    expect_step(8'h02, t + 2);
    En = 1'b1;
    stop_at(t + 2);
    drain("rcv5_seq");
    chk("rcv_dir_left", 32'(dut.dir_r), 32'd0);

    repeat (2) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
